mux_2x2_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4-input, 2-bit-wide multiplexer path among four requesters.
- Each requester presents 2-bit data and a request line.
- The block grants one requester at a time and drives the 2-bit mux select key.
- It registers the selected data with a valid flag for the downstream consumer.
- Grants are held while the request stays high, up to MAX_HOLD cycles, then rotate.

---
 rtl/mux_2x2_rr_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux_2x2_rr_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux_2x2_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1, 2-bit data path among four requesters.
//
// Ports:
//   clk        - single clock, rising edge.
//   reset      - asynchronous, active-high reset.
//   req[3:0]   - request lines, req[i] belongs to requester i.
//   in1..in4   - 2-bit data of requesters 0..3.
//   gnt[3:0]   - registered one-hot grant, zero when idle.
//   key[1:0]   - registered mux select, index of current/last grantee.
//   busy       - registered, high while a grant is active.
//   out[1:0]   - registered data of the requester granted in the previous cycle.
//   out_valid  - registered, high for the cycle after each granted cycle.
//
// A grant is held while its request stays high, for at most MAX_HOLD cycles,
// after which the next requester in rotation order is granted on the same edge.
module mux_2x2_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] in1,
  input  logic [1:0] in2,
  input  logic [1:0] in3,
  input  logic [1:0] in4,
  output logic [3:0] gnt,
  output logic [1:0] key,
  output logic       busy,
  output logic [1:0] out,
  output logic       out_valid
);

  localparam logic [2:0] MaxHold = 3'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] key_q, key_d;
  logic [1:0] last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [1:0] search_start;
  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;

  // First requesting index at or after search_start, wrapping mod 4.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = search_start;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = idx + 2'd1;
    end
  end

  // In IDLE the search follows the last-grant pointer; on release it starts
  // just past the current grantee (which equals last while granting).
  always_comb begin
    search_start = (state_q == StIdle) ? last_q + 2'd1 : key_q + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    key_d   = key_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << winner;
          key_d   = winner;
          last_d  = winner;
          cnt_d   = 3'd1;
        end else begin
          gnt_d = 4'b0000;
        end
      end
      StGrant: begin
        if (req[key_q] && (cnt_q < MaxHold)) begin
          cnt_d = cnt_q + 3'd1;
        end else if (found) begin
          // Hand over directly, no idle bubble; may re-grant the same requester.
          gnt_d  = 4'b0001 << winner;
          key_d  = winner;
          last_d = winner;
          cnt_d  = 3'd1;
        end else begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Data path lags the grant by one cycle: it captures the grantee's data.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (state_q == StGrant) begin
      out_valid_d = 1'b1;
      unique case (key_q)
        2'd0: out_d = in1;
        2'd1: out_d = in2;
        2'd2: out_d = in3;
        2'd3: out_d = in4;
        default: out_d = in1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      gnt_q       <= 4'b0000;
      key_q       <= 2'd0;
      last_q      <= 2'd3;
      cnt_q       <= 3'd0;
      out_q       <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      key_q       <= key_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign key       = key_q;
  assign busy      = (state_q == StGrant);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_2x2_rr_arbiter.sv
// Directed bench for mux_2x2_rr_arbiter. Two instances share the inputs:
// u_dut4 with MAX_HOLD=4 and u_dut2 with MAX_HOLD=2.
// Outputs are compared packed as {gnt, key, busy, out, out_valid}.
module tb_mux_2x2_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [1:0] in1, in2, in3, in4;

  logic [3:0] gnt4, gnt2;
  logic [1:0] key4, key2;
  logic       busy4, busy2;
  logic [1:0] out4, out2;
  logic       out_valid4, out_valid2;

  int n_vec;
  int n_err;

  mux_2x2_rr_arbiter #(.MAX_HOLD(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .gnt       (gnt4),
    .key       (key4),
    .busy      (busy4),
    .out       (out4),
    .out_valid (out_valid4)
  );

  mux_2x2_rr_arbiter #(.MAX_HOLD(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in4       (in4),
    .gnt       (gnt2),
    .key       (key2),
    .busy      (busy2),
    .out       (out2),
    .out_valid (out_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] pk(logic [3:0] g, logic [1:0] k, logic b, logic [1:0] o,
                                    logic v);
    return {g, k, b, o, v};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got gnt/key/busy/out/vld=%b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] dat [4];
  int         seq [10];
  int         g;

  initial begin
    n_vec = 0;
    n_err = 0;
    dat[0] = 2'b11; dat[1] = 2'b01; dat[2] = 2'b10; dat[3] = 2'b00;
    seq[0] = 0; seq[1] = 0; seq[2] = 1; seq[3] = 1; seq[4] = 2;
    seq[5] = 2; seq[6] = 3; seq[7] = 3; seq[8] = 0; seq[9] = 0;
    in1 = dat[0]; in2 = dat[1]; in3 = dat[2]; in4 = dat[3];
    req   = 4'b0000;
    reset = 1'b1;

    // 1. Reset forces all outputs before any clock edge.
    #2;
    chk("reset_async4", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b0, 2'd0, 0, 2'b00, 0));
    chk("reset_async2", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0, 2'd0, 0, 2'b00, 0));
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_c%0d", i), pk(gnt4, key4, busy4, out4, out_valid4),
          pk(4'b0, 2'd0, 0, 2'b00, 0));
    end

    // 2. Single requester 2 on MAX_HOLD=4: re-granted on expiry without a gap.
    req = 4'b0100;
    step();
    chk("single_c0", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b0100, 2'd2, 1, 2'b00, 0));
    for (int i = 1; i < 10; i++) begin
      step();
      chk($sformatf("single_c%0d", i), pk(gnt4, key4, busy4, out4, out_valid4),
          pk(4'b0100, 2'd2, 1, 2'b10, 1));
    end

    // 5. Sole grantee drops: idle, key held, out_valid falls one cycle later.
    req = 4'b0000;
    step();
    chk("idle_ret0", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b0000, 2'd2, 0, 2'b10, 1));
    step();
    chk("idle_ret1", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b0000, 2'd2, 0, 2'b10, 0));

    // 3. All requesting on MAX_HOLD=2: 0,0,1,1,2,2,3,3,0,0 from a fresh reset.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      g = seq[i];
      chk($sformatf("rr_c%0d", i), pk(gnt2, key2, busy2, out2, out_valid2),
          pk(4'b0001 << g, 2'(g), 1, (i == 0) ? 2'b00 : dat[seq[i-1]], (i != 0)));
    end

    // 6. Continue rotation to requester 2, then reset mid-grant.
    step();
    chk("rr_c10", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0010, 2'd1, 1, dat[0], 1));
    step();
    chk("rr_c11", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0010, 2'd1, 1, dat[1], 1));
    step();
    chk("rr_c12", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0100, 2'd2, 1, dat[1], 1));
    reset = 1'b1;
    #1;
    chk("mid_reset", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0, 2'd0, 0, 2'b00, 0));
    #1;
    reset = 1'b0;
    step();
    chk("post_reset", pk(gnt2, key2, busy2, out2, out_valid2), pk(4'b0001, 2'd0, 1, 2'b00, 0));

    // 4. Early release: requester 1 drops, requester 3 granted with no idle cycle.
    #1;
    reset = 1'b1;
    req = 4'b1010;
    #1;
    reset = 1'b0;
    step();
    chk("early_c0", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b0010, 2'd1, 1, 2'b00, 0));
    req = 4'b1000;
    step();
    chk("early_c1", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b1000, 2'd3, 1, dat[1], 1));
    step();
    chk("early_c2", pk(gnt4, key4, busy4, out4, out_valid4), pk(4'b1000, 2'd3, 1, dat[3], 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
